// File: rtl/gpio_pkg.sv
// Shared types and widths for the GPIO output controller: FSM states, lane geometry, counter width.
package gpio_pkg;

    localparam int LANE_W     = 8;
    localparam int LANES      = 4;
    localparam int LANE_SEL_W = 2;
    localparam int GPIO_W     = LANE_W * LANES;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } gpio_state_e;

endpackage

// File: rtl/gpio_out_ctrl_if.sv
// Write/commit bus and published GPIO word with its ext_clk qualifier.
interface gpio_out_ctrl_if;
    import gpio_pkg::*;

    logic                  wr_en;
    logic [LANE_SEL_W-1:0] wr_lane;
    logic [LANE_W-1:0]     wr_data;
    logic                  commit;
    logic                  clr_ovr;
    logic [GPIO_W-1:0]     gpio;
    logic                  ext_clk;
    logic                  busy;
    logic                  overrun;

    modport master (
        output wr_en, wr_lane, wr_data, commit, clr_ovr,
        input  gpio, ext_clk, busy, overrun
    );

    modport slave (
        input  wr_en, wr_lane, wr_data, commit, clr_ovr,
        output gpio, ext_clk, busy, overrun
    );

endinterface

// File: rtl/gpio_phase_cnt.sv
// Phase length counter: load on phase entry, count down to zero, hold at zero.
module gpio_phase_cnt
    import gpio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gpio_out_ctrl.sv
// Byte-staged 32-bit GPIO publisher: each commit drives a new word together with a timed ext_clk pulse.
module gpio_out_ctrl
    import gpio_pkg::*;
#(
    parameter int HIGH_CYCLES = 5,
    parameter int LOW_CYCLES  = 5
)
(
    input  logic            clk,
    input  logic            rst,
    gpio_out_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

    gpio_state_e       r_state;
    gpio_state_e       w_next_state;

    logic [GPIO_W-1:0] r_staging;
    logic [GPIO_W-1:0] w_merged;
    logic [GPIO_W-1:0] r_pend_data;
    logic [GPIO_W-1:0] r_gpio;
    logic [GPIO_W-1:0] w_pub_data;
    logic              r_pending;
    logic              r_ext_clk;
    logic              r_overrun;

    logic              w_zero;
    logic              w_busy;
    logic              w_publish;
    logic              w_consume;
    logic              w_ext_fall;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_pend_load;
    logic              w_ovr_event;

    // Same-cycle write is merged so a coincident commit sees the new byte.
    always_comb begin
        w_merged = r_staging;
        if (bus.wr_en) begin
            w_merged[{bus.wr_lane, 3'b000} +: LANE_W] = bus.wr_data;
        end
    end

    gpio_phase_cnt u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (r_pending || bus.commit) w_next_state = ST_HIGH;
            ST_HIGH: if (w_zero) w_next_state = ST_LOW;
            ST_LOW:  if (w_zero) w_next_state = r_pending ? ST_HIGH : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != ST_IDLE) || r_pending;
        w_publish   = ((r_state == ST_IDLE) && (r_pending || bus.commit)) ||
                      ((r_state == ST_LOW) && w_zero && r_pending);
        w_pub_data  = r_pending ? r_pend_data : w_merged;
        w_consume   = w_publish && r_pending;
        w_ext_fall  = (r_state == ST_HIGH) && w_zero;
        w_cnt_load  = w_publish || w_ext_fall;
        w_cnt_val   = w_publish ? HIGH_LOAD : LOW_LOAD;
        w_cnt_dec   = (r_state != ST_IDLE);
        // A slot freed by this cycle's publish can take a new commit without overrun.
        w_pend_load = bus.commit && w_busy && (!r_pending || w_consume);
        w_ovr_event = bus.commit && r_pending && !w_consume;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_staging   <= '0;
            r_gpio      <= '0;
            r_ext_clk   <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_data <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_staging <= w_merged;

            if (w_publish) begin
                r_gpio    <= w_pub_data;
                r_ext_clk <= 1'b1;
            end else if (w_ext_fall) begin
                r_ext_clk <= 1'b0;
            end

            if (w_pend_load) begin
                r_pending   <= 1'b1;
                r_pend_data <= w_merged;
            end else if (w_consume) begin
                r_pending   <= 1'b0;
            end

            if (w_ovr_event) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.gpio    = r_gpio;
    assign bus.ext_clk = r_ext_clk;
    assign bus.busy    = w_busy;
    assign bus.overrun = r_overrun;

endmodule
